and4: RTL and testbench
=======================

// Module: and4
//
// PURPOSE
//   Four-input AND gate, bitwise over WIDTH-bit operands.
//   Combinational output o = a & b & c & d, plus a registered copy o_r for timing-closed consumers.
//   Basic logic primitive used wherever a 4-way conjunction of enables or flags is needed.
//   Optional saturating counter of cycles in which every bit of o is 1.
//
// PARAMETERS
//   WIDTH   1    bit width of a, b, c, d, o, o_r (must be >= 1)
//   CNT_W   16   width of hit_cnt (only used when AND4_STATS_EN is defined; must be >= 1)
//
// PORTS
//   clk      in   1      single clock; all state updates on rising edge
//   rst      in   1      synchronous reset, active-high
//   a        in   WIDTH  operand 0
//   b        in   WIDTH  operand 1
//   c        in   WIDTH  operand 2
//   d        in   WIDTH  operand 3
//   o        out  WIDTH  combinational a & b & c & d
//   o_r      out  WIDTH  o registered one cycle
//   all_one  out  1      combinational &o (every bit of o is 1)
//   hit_cnt  out  CNT_W  saturating count of cycles with all_one=1 (AND4_STATS_EN only)
//
// BEHAVIOUR
//   - One clock (clk); reset is synchronous and active-high (rst).
//   - o: purely combinational, zero latency, independent of clk/rst.
//     Bit i = a[i] & b[i] & c[i] & d[i].
//     X/Z on any input propagates per standard Verilog & semantics.
//   - all_one: combinational reduction AND of o; zero latency.
//   - o_r: on rising clk, if rst then o_r <= 0, else o_r <= o. Latency is exactly 1 cycle.
//   - Reset values: o_r = 0, hit_cnt = 0. o and all_one are not affected by rst.
//   - Reset asserted mid-operation clears o_r at the next edge. o keeps tracking the inputs.
//   - Input changes between edges are visible on o immediately and on o_r only at the next edge.
//   - No handshake, no state machine, no internal state except o_r and hit_cnt.
//
// CONFIGURATION
//   AND4_STATS_EN defined:
//     - hit_cnt increments by 1 on each rising clk where rst=0 and all_one=1.
//     - Saturates at 2^CNT_W-1; no wrap.
//     - rst clears it to 0; rst has priority over an increment in the same cycle.
//   AND4_STATS_EN undefined:
//     - hit_cnt is still a port, tied to 0.
//     - No counter logic is synthesized.
//
// TESTING
//   - WIDTH=1 exhaustive truth table, 16 combos 0000..1111 applied 1 time unit apart:
//     o=0 for all except a=b=c=d=1 -> o=1.
//   - WIDTH=8, a=FF b=F0 c=3C d=FF -> o=30 same delta, all_one=0; o_r=30 after one clk edge.
//   - Hold rst=1 for 2 edges with all inputs 1 -> o=1, o_r=0.
//     Deassert rst -> o_r=1 at the next edge.
//   - AND4_STATS_EN, CNT_W=2, all inputs 1 for 5 edges -> hit_cnt 1,2,3,3,3 (saturates).
//     Then rst for 1 edge -> 0.
//   - AND4_STATS_EN, inputs toggling a=0/1 per cycle for 4 edges, others 1 -> hit_cnt=2.
//   - AND4_STATS_EN undefined -> hit_cnt stays 0 throughout all of the above.

Source files
------------

// File: rtl/and4.sv
// ---------------------------------------------------------------------------
// and4 : bitwise four-input AND gate with a registered copy of the result.
//
// Optional feature macro: AND4_STATS_EN
//   When defined, hit_cnt is a saturating count of clock cycles in which
//   every bit of o is 1. When undefined, hit_cnt is tied to zero and no
//   counter logic exists.
//
// Parameters
//   WIDTH  operand / result width (>= 1)
//   CNT_W  hit_cnt width (>= 1, only meaningful with AND4_STATS_EN)
//
// Ports
//   clk      rising-edge clock for o_r and hit_cnt
//   rst      synchronous active-high reset (clears o_r and hit_cnt)
//   a,b,c,d  WIDTH-bit operands
//   o        combinational a & b & c & d
//   o_r      o delayed by exactly one clock
//   all_one  combinational reduction AND of o
//   hit_cnt  saturating count of cycles with all_one = 1 (0 when disabled)
// ---------------------------------------------------------------------------
module and4 #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_r,
    output logic             all_one,
    output logic [CNT_W-1:0] hit_cnt
);

    logic [WIDTH-1:0] o_r_reg;

    // Per-bit conjunction; the explicit bit loop keeps X/Z propagation
    // identical to a plain vector AND.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign o[gi] = a[gi] & b[gi] & c[gi] & d[gi];
        end
    endgenerate

    assign all_one = &o;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_r_reg <= '0;
        end else begin
            o_r_reg <= o;
        end
    end

    assign o_r = o_r_reg;

`ifdef AND4_STATS_EN
    logic [CNT_W-1:0] hit_cnt_reg;

    // Reset wins over an increment in the same cycle; the count holds at
    // all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_reg <= '0;
        end else if (all_one && (hit_cnt_reg != {CNT_W{1'b1}})) begin
            hit_cnt_reg <= hit_cnt_reg + 1'b1;
        end
    end

    assign hit_cnt = hit_cnt_reg;
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_and4.sv
module tb_and4;

`ifdef AND4_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=1 instance with a 2-bit counter (truth table, reset, saturation)
    logic       rst1;
    logic       a1, b1, c1, d1;
    logic       o1, o_r1, all_one1;
    logic [1:0] hit_cnt1;

    // WIDTH=8 instance (bitwise pattern)
    logic       rst8;
    logic [7:0] a8, b8, c8, d8;
    logic [7:0] o8, o_r8;
    logic       all_one8;
    logic [1:0] hit_cnt8;

    and4 #(.WIDTH(1), .CNT_W(2)) u_w1 (
        .clk(clk), .rst(rst1), .a(a1), .b(b1), .c(c1), .d(d1),
        .o(o1), .o_r(o_r1), .all_one(all_one1), .hit_cnt(hit_cnt1)
    );

    and4 #(.WIDTH(8), .CNT_W(2)) u_w8 (
        .clk(clk), .rst(rst8), .a(a8), .b(b8), .c(c8), .d(d8),
        .o(o8), .o_r(o_r8), .all_one(all_one8), .hit_cnt(hit_cnt8)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] v;
        rst1 = 1'b1; {a1, b1, c1, d1} = 4'b0000;
        rst8 = 1'b1; a8 = 8'h00; b8 = 8'h00; c8 = 8'h00; d8 = 8'h00;
        tick();
        tick();
        check("reset_o_r1", o_r1, 0);
        check("reset_cnt1", hit_cnt1, 0);
        check("reset_o_r8", o_r8, 0);
        check("reset_cnt8", hit_cnt8, 0);
        rst8 = 1'b0;

        // WIDTH=1 exhaustive truth table, 1 time unit apart (rst1 held)
        for (int i = 0; i < 16; i++) begin
            v = i[3:0];
            {a1, b1, c1, d1} = v;
            #1;
            check($sformatf("tt_o_%0d", i), o1, (i == 15) ? 1 : 0);
            check($sformatf("tt_all_one_%0d", i), all_one1, (i == 15) ? 1 : 0);
        end
        check("tt_o_r_in_reset", o_r1, 0);

        // WIDTH=8 pattern
        tick();
        a8 = 8'hFF; b8 = 8'hF0; c8 = 8'h3C; d8 = 8'hFF;
        #1;
        check("w8_o", o8, 32'h30);
        check("w8_all_one", all_one8, 0);
        check("w8_o_r_before_edge", o_r8, 0);
        tick();
        check("w8_o_r_after_edge", o_r8, 32'h30);
        check("w8_cnt_no_hit", hit_cnt8, 0);
        b8 = 8'hFF; c8 = 8'hFF;
        #1;
        check("w8_o_ff", o8, 32'hFF);
        check("w8_all_one_ff", all_one8, 1);
        check("w8_o_r_hold", o_r8, 32'h30);
        tick();
        check("w8_o_r_ff", o_r8, 32'hFF);
        check("w8_cnt_hit", hit_cnt8, STATS ? 1 : 0);

        // Reset held two edges with all inputs 1
        {a1, b1, c1, d1} = 4'b1111;
        tick();
        tick();
        check("rst_o", o1, 1);
        check("rst_o_r", o_r1, 0);
        check("rst_cnt", hit_cnt1, 0);

        // Release reset: o_r follows on next edge, counter saturates at 3
        rst1 = 1'b0;
        tick();
        check("rel_o_r", o_r1, 1);
        check("sat_cnt_1", hit_cnt1, STATS ? 1 : 0);
        tick();
        check("sat_cnt_2", hit_cnt1, STATS ? 2 : 0);
        tick();
        check("sat_cnt_3", hit_cnt1, STATS ? 3 : 0);
        tick();
        check("sat_cnt_4", hit_cnt1, STATS ? 3 : 0);
        tick();
        check("sat_cnt_5", hit_cnt1, STATS ? 3 : 0);

        // Mid-operation reset with all_one=1: reset wins
        rst1 = 1'b1;
        tick();
        check("mid_rst_cnt", hit_cnt1, 0);
        check("mid_rst_o_r", o_r1, 0);
        check("mid_rst_o", o1, 1);
        rst1 = 1'b0;

        // Toggle a for 4 edges: 0,1,0,1 -> two hits
        a1 = 1'b0;
        #1;
        check("tog_o_a0", o1, 0);
        tick();
        check("tog_cnt_e1", hit_cnt1, 0);
        check("tog_o_r_e1", o_r1, 0);
        a1 = 1'b1;
        tick();
        check("tog_cnt_e2", hit_cnt1, STATS ? 1 : 0);
        check("tog_o_r_e2", o_r1, 1);
        a1 = 1'b0;
        tick();
        check("tog_o_r_e3", o_r1, 0);
        a1 = 1'b1;
        tick();
        check("tog_cnt_e4", hit_cnt1, STATS ? 2 : 0);
        check("tog_o_r_e4", o_r1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
